fp_unpack: RTL and testbench

Two-operand IEEE-754 unpacker for the floating-point adder datapath. Accepts packed operands A and B and splits each into sign, original biased exponent, re-biased exponent and mantissa. The re-biased exponent uses the encoding the special-case stage checks (Inf/NaN = BIAS, zero/subnormal = BIAS+1 as a signed value). A class code is attached to each operand. The block is a 2-stage, valid/ready, full-throughput pipeline that feeds the special-case and alignment stages.

---
 rtl/fp_unpack_pkg.sv | 23 ++
 rtl/fp_classify.sv | 52 +++++
 rtl/fp_unpack.sv | 141 ++++++++++++++
 tb/tb_fp_unpack.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_unpack_pkg.sv
// rtl/fp_unpack_pkg.sv - shared floating-point constants for the adder datapath
// Purpose: class codes, default field widths and the exponent bias derivation
//          used by the unpacker and the downstream adder stages.
package fp_unpack_pkg;

  // Default packed-operand field widths (single precision): {sign, exp, mnt}
  localparam int FP_E_WIDTH = 8;
  localparam int FP_M_WIDTH = 23;

  // Operand class codes
  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_SUBN   = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_QNAN   = 3'd4;
  localparam logic [2:0] CLS_SNAN   = 3'd5;

  // Exponent bias is always derived from the exponent width, never overridden
  function automatic int fp_bias(input int e_width);
    return 1 << (e_width - 1);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational exponent re-bias, hidden bit and class decode
// Purpose: maps one operand's {exp_org, mnt} to {exp, hid, cls}.
// Ports:
//   i_exp_org  biased exponent field as received
//   i_mnt      mantissa field (hidden bit excluded)
//   o_exp      re-biased exponent: exp_org - (BIAS-1) modulo 2^E_WIDTH
//   o_hid      hidden bit, 0 when exp_org is zero
//   o_cls      class code (zero/subnormal/normal/inf/qNaN/sNaN)
module fp_classify
  import fp_unpack_pkg::*;
#(
  parameter int E_WIDTH = FP_E_WIDTH,
  parameter int M_WIDTH = FP_M_WIDTH
) (
  input  logic [E_WIDTH-1:0] i_exp_org,
  input  logic [M_WIDTH-1:0] i_mnt,
  output logic [E_WIDTH-1:0] o_exp,
  output logic               o_hid,
  output logic [2:0]         o_cls
);

  localparam logic [E_WIDTH-1:0] REBIAS = E_WIDTH'(fp_bias(E_WIDTH) - 1);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_mnt_zero;

  assign w_exp_zero = (i_exp_org == '0);
  assign w_exp_ones = &i_exp_org;
  assign w_mnt_zero = (i_mnt == '0);

  // Wrapping subtract: all-ones lands on BIAS, zero lands on BIAS+1, which is
  // the encoding the special-case stage keys on.
  assign o_exp = i_exp_org - REBIAS;
  assign o_hid = ~w_exp_zero;

  always_comb begin
    o_cls = CLS_NORMAL;
    if (w_exp_zero) begin
      o_cls = w_mnt_zero ? CLS_ZERO : CLS_SUBN;
    end else if (w_exp_ones) begin
      if (w_mnt_zero) begin
        o_cls = CLS_INF;
      end else if (i_mnt[M_WIDTH-1]) begin
        o_cls = CLS_QNAN;
      end else begin
        o_cls = CLS_SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - two-operand IEEE-754 unpacker, 2-stage valid/ready pipeline
// Purpose: splits operands A and B into sign, original and re-biased exponent,
//          mantissa, hidden bit and class code for the adder datapath.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        operand pair handshake (op_A, op_B packed)
//   out_valid/out_ready      unpacked pair handshake
//   sign_*, exp_*_org, exp_*, mnt_*, hid_*, cls_*   unpacked fields per operand
module fp_unpack
  import fp_unpack_pkg::*;
#(
  parameter int E_WIDTH = FP_E_WIDTH,
  parameter int M_WIDTH = FP_M_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [E_WIDTH+M_WIDTH:0]   op_A,
  input  logic [E_WIDTH+M_WIDTH:0]   op_B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sign_A,
  output logic                       sign_B,
  output logic [E_WIDTH-1:0]         exp_A_org,
  output logic [E_WIDTH-1:0]         exp_B_org,
  output logic [E_WIDTH-1:0]         exp_A,
  output logic [E_WIDTH-1:0]         exp_B,
  output logic [M_WIDTH-1:0]         mnt_A,
  output logic [M_WIDTH-1:0]         mnt_B,
  output logic                       hid_A,
  output logic                       hid_B,
  output logic [2:0]                 cls_A,
  output logic [2:0]                 cls_B
);

  localparam int W = E_WIDTH + M_WIDTH + 1;

  // Stage 1: raw packed operands
  logic         r_v1;
  logic [W-1:0] r_op_a;
  logic [W-1:0] r_op_b;

  // Stage 2: unpacked fields
  logic               r_v2;
  logic               r_sign_a,    r_sign_b;
  logic [E_WIDTH-1:0] r_exp_org_a, r_exp_org_b;
  logic [E_WIDTH-1:0] r_exp_a,     r_exp_b;
  logic [M_WIDTH-1:0] r_mnt_a,     r_mnt_b;
  logic               r_hid_a,     r_hid_b;
  logic [2:0]         r_cls_a,     r_cls_b;

  logic               w_adv1, w_adv2;
  logic [E_WIDTH-1:0] w_exp_a, w_exp_b;
  logic               w_hid_a, w_hid_b;
  logic [2:0]         w_cls_a, w_cls_b;

  // Ready ripples back combinationally so a full pipe restarts without a bubble
  assign w_adv2   = ~r_v2 | out_ready;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = w_adv1;

  fp_classify #(.E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) u_cls_a (
    .i_exp_org (r_op_a[W-2 -: E_WIDTH]),
    .i_mnt     (r_op_a[M_WIDTH-1:0]),
    .o_exp     (w_exp_a),
    .o_hid     (w_hid_a),
    .o_cls     (w_cls_a)
  );

  fp_classify #(.E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) u_cls_b (
    .i_exp_org (r_op_b[W-2 -: E_WIDTH]),
    .i_mnt     (r_op_b[M_WIDTH-1:0]),
    .o_exp     (w_exp_b),
    .o_hid     (w_hid_b),
    .o_cls     (w_cls_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1   <= 1'b0;
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_op_a <= op_A;
        r_op_b <= op_B;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2        <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_exp_org_a <= '0;
      r_exp_org_b <= '0;
      r_exp_a     <= '0;
      r_exp_b     <= '0;
      r_mnt_a     <= '0;
      r_mnt_b     <= '0;
      r_hid_a     <= 1'b0;
      r_hid_b     <= 1'b0;
      r_cls_a     <= CLS_ZERO;
      r_cls_b     <= CLS_ZERO;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign_a    <= r_op_a[W-1];
        r_sign_b    <= r_op_b[W-1];
        r_exp_org_a <= r_op_a[W-2 -: E_WIDTH];
        r_exp_org_b <= r_op_b[W-2 -: E_WIDTH];
        r_exp_a     <= w_exp_a;
        r_exp_b     <= w_exp_b;
        r_mnt_a     <= r_op_a[M_WIDTH-1:0];
        r_mnt_b     <= r_op_b[M_WIDTH-1:0];
        r_hid_a     <= w_hid_a;
        r_hid_b     <= w_hid_b;
        r_cls_a     <= w_cls_a;
        r_cls_b     <= w_cls_b;
      end
    end
  end

  assign out_valid = r_v2;
  assign sign_A    = r_sign_a;
  assign sign_B    = r_sign_b;
  assign exp_A_org = r_exp_org_a;
  assign exp_B_org = r_exp_org_b;
  assign exp_A     = r_exp_a;
  assign exp_B     = r_exp_b;
  assign mnt_A     = r_mnt_a;
  assign mnt_B     = r_mnt_b;
  assign hid_A     = r_hid_a;
  assign hid_B     = r_hid_b;
  assign cls_A     = r_cls_a;
  assign cls_B     = r_cls_b;

endmodule

// File: tb/tb_fp_unpack.sv
// tb/tb_fp_unpack.sv - directed self-checking bench for fp_unpack
module tb_fp_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_A, op_B;
  logic        out_valid;
  logic        out_ready;
  logic        sign_A, sign_B;
  logic [7:0]  exp_A_org, exp_B_org, exp_A, exp_B;
  logic [22:0] mnt_A, mnt_B;
  logic        hid_A, hid_B;
  logic [2:0]  cls_A, cls_B;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_unpack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_A      (op_A),
    .op_B      (op_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_A    (sign_A),
    .sign_B    (sign_B),
    .exp_A_org (exp_A_org),
    .exp_B_org (exp_B_org),
    .exp_A     (exp_A),
    .exp_B     (exp_B),
    .mnt_A     (mnt_A),
    .mnt_B     (mnt_B),
    .hid_A     (hid_A),
    .hid_B     (hid_B),
    .cls_A     (cls_A),
    .cls_B     (cls_B)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair into an empty pipe with out_ready high; returns once the
  // pair should be on the outputs (second edge after acceptance).
  task automatic run_vec(input logic [31:0] a, input logic [31:0] b);
    op_A = a;
    op_B = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rv_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("rv_lat_edge1", out_valid, 0);
    tick();
    check("rv_lat_edge2", out_valid, 1);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  int  sent, rcvd;
  logic fire_in, prev_stall;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_A = '0;
    op_B = '0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_cls_A", cls_A, 0);
    check("rst_exp_A", exp_A, 0);
    check("rst_exp_B", exp_B, 0);
    check("rst_mnt_B", mnt_B, 0);
    rst = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_post", out_valid, 0);

    // 1.0 and +0
    run_vec(32'h3F800000, 32'h00000000);
    check("v1_exp_A", exp_A, 8'h00);
    check("v1_hid_A", hid_A, 1);
    check("v1_cls_A", cls_A, 2);
    check("v1_exp_A_org", exp_A_org, 8'h7F);
    check("v1_exp_B", exp_B, 8'h81);
    check("v1_hid_B", hid_B, 0);
    check("v1_cls_B", cls_B, 0);

    // +Inf and -Inf
    run_vec(32'h7F800000, 32'hFF800000);
    check("v2_exp_A", exp_A, 8'h80);
    check("v2_exp_B", exp_B, 8'h80);
    check("v2_cls_A", cls_A, 3);
    check("v2_cls_B", cls_B, 3);
    check("v2_sign_A", sign_A, 0);
    check("v2_sign_B", sign_B, 1);
    check("v2_exp_A_org", exp_A_org, 8'hFF);
    check("v2_mnt_A", mnt_A, 0);

    // qNaN and sNaN with payloads kept
    run_vec(32'h7FC00001, 32'h7F800001);
    check("v3_cls_A", cls_A, 4);
    check("v3_cls_B", cls_B, 5);
    check("v3_mnt_A", mnt_A, 23'h400001);
    check("v3_mnt_B", mnt_B, 23'h000001);

    // Smallest subnormal and smallest normal (exp_org 0x01)
    run_vec(32'h00000001, 32'h00800000);
    check("v4_cls_A", cls_A, 1);
    check("v4_exp_A", exp_A, 8'h81);
    check("v4_mnt_A", mnt_A, 1);
    check("v4_hid_A", hid_A, 0);
    check("v4_exp_B", exp_B, 8'h82);
    check("v4_cls_B", cls_B, 2);
    check("v4_hid_B", hid_B, 1);

    // Largest normal (exp_org 0xFE), -0, and an sNaN with a high payload bit
    run_vec(32'h7F7FFFFF, 32'h80000000);
    check("v5_exp_A", exp_A, 8'h7F);
    check("v5_cls_A", cls_A, 2);
    check("v5_hid_A", hid_A, 1);
    check("v5_mnt_A", mnt_A, 23'h7FFFFF);
    check("v5_sign_B", sign_B, 1);
    check("v5_cls_B", cls_B, 0);
    check("v5_exp_B", exp_B, 8'h81);
    run_vec(32'hFFA00000, 32'h40490FDB);
    check("v6_cls_A", cls_A, 5);
    check("v6_sign_A", sign_A, 1);
    check("v6_exp_B", exp_B, 8'h01);
    check("v6_cls_B", cls_B, 2);
    tick();
    check("drain_out_valid", out_valid, 0);

    // Stream of 8 pairs with out_ready pattern 1,0,0,1,0,0,...
    for (int i = 0; i < 8; i++) begin
      sa[i] = 32'h3F800000 + (i * 32'h01234567);
      sb[i] = 32'hC0000000 ^ (i * 32'h00A5F00F);
    end
    sent = 0;
    rcvd = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      in_valid = (sent < 8);
      if (sent < 8) begin
        op_A = sa[sent];
        op_B = sb[sent];
      end
      #1;
      check("st_in_ready", in_ready, !((sent - rcvd) == 2 && !out_ready));
      if (prev_stall) check("st_hold_valid", out_valid, 1);
      prev_stall = 1'b0;
      if (out_valid) begin
        check("st_data_A", {sign_A, exp_A_org, mnt_A}, sa[rcvd]);
        check("st_data_B", {sign_B, exp_B_org, mnt_B}, sb[rcvd]);
        if (out_ready) rcvd++;
        else prev_stall = 1'b1;
      end
      fire_in = in_valid && in_ready;
      tick();
      if (fire_in) sent++;
    end
    in_valid = 1'b0;
    check("st_sent", sent, 8);
    check("st_rcvd", rcvd, 8);
    out_ready = 1'b1;
    tick();
    tick();
    check("st_empty", out_valid, 0);

    // Fill the pipe with out_ready low
    out_ready = 1'b0;
    op_A = 32'h3F800000;
    op_B = 32'h40000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    check("fill_s2_only_ready", in_ready, 1);
    check("fill_s2_valid", out_valid, 1);
    op_A = 32'h40400000;
    op_B = 32'h40800000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("fill_full_ready", in_ready, 0);
    check("fill_hold_A", {sign_A, exp_A_org, mnt_A}, 32'h3F800000);
    out_ready = 1'b1;
    #1;
    check("fill_ready_rise", in_ready, 1);
    out_ready = 1'b0;
    #1;

    // Reset pulse with a full pipe
    rst = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_exp_A_org", exp_A_org, 0);
    check("mrst_exp_A", exp_A, 0);
    check("mrst_cls_A", cls_A, 0);
    check("mrst_hid_A", hid_A, 0);
    check("mrst_mnt_A", mnt_A, 0);
    check("mrst_sign_B", sign_B, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mrst_post1_valid", out_valid, 0);
    tick();
    check("mrst_post2_valid", out_valid, 0);
    run_vec(32'h00800000, 32'h7F7FFFFF);
    check("mrst_new_A_org", exp_A_org, 8'h01);
    check("mrst_new_exp_A", exp_A, 8'h82);
    check("mrst_new_exp_B", exp_B, 8'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
